// File: rtl/instr_prefetch_if.sv
// Bundle between the prefetch buffer, the main-memory read port and the issue stage.
// The prefetch buffer drives through the master modport; the environment uses slave.
interface instr_prefetch_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_req;
    logic [AW-1:0] mem_raddr;
    logic          mem_gnt;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [CW-1:0] occupancy;

    modport master (
        output mem_req, mem_raddr, instr_valid, instr_data, instr_pc, occupancy,
        input  mem_gnt, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_raddr, instr_valid, instr_data, instr_pc, occupancy,
        output mem_gnt, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: fetches ahead into a DEPTH-entry {pc, instr} FIFO,
// hands entries to issue over valid/ready, and flushes/restarts on a redirect.
module instr_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_prefetch_if.master     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, KILL} ctl_e;

    entry_t [DEPTH-1:0] buf_q, buf_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [AW-1:0]      fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    ctl_e               state_q, state_d;

    logic               inflight, kill;
    logic [CW:0]        used;
    logic               grant, push, pop;

    // Control FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Control FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid)
            state_d = (state_q == WAIT) ? KILL : IDLE;
        else if (grant)
            state_d = WAIT;
        else
            state_d = IDLE;
    end

    // Control FSM: outputs
    always_comb begin
        inflight = (state_q == WAIT);
        kill     = (state_q == KILL);
    end

    // In-flight request holds a FIFO slot so its response can always be written.
    // The request is gated by reset so the port is quiet while held in reset.
    always_comb begin
        used            = {1'b0, occ_q} + (CW+1)'(inflight);
        bus.mem_req     = rst && (used < (CW+1)'(DEPTH)) && !bus.redirect_valid;
        bus.mem_raddr   = fetch_pc_q;
        bus.instr_valid = (occ_q != '0) && !bus.redirect_valid;
        bus.instr_data  = buf_q[rd_ptr_q].data;
        bus.instr_pc    = buf_q[rd_ptr_q].pc;
        bus.occupancy   = occ_q;
        grant           = bus.mem_req && bus.mem_gnt;
        push            = inflight && !kill && !bus.redirect_valid;
        pop             = bus.instr_valid && bus.instr_ready;
    end

    always_comb begin
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (bus.redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + AW'(1);
                rsp_pc_d   = fetch_pc_q;
            end
            if (push) begin
                buf_d[wr_ptr_q] = '{pc: rsp_pc_q, data: bus.mem_rdata};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            fetch_pc_q <= '0;
            rsp_pc_q   <= '0;
        end else begin
            buf_q      <= buf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
        end
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized and directed bench for instr_prefetch_buffer against a queue-based model.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_prefetch_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    instr_prefetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } ent_t;

    // model state
    ent_t          q[$];
    logic [AW-1:0] m_fetch;
    logic [AW-1:0] m_rsp_pc;
    bit            m_infl, m_kill;
    logic [AW-1:0] grants[$];
    logic [AW-1:0] popped[$];

    // stimulus
    bit            gnt, rdy, rdr;
    logic [AW-1:0] rpc;

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(32'h1000) + DW'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch  = '0;
        m_rsp_pc = '0;
        m_infl   = 0;
        m_kill   = 0;
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step();
        bit exp_req, exp_vld, do_grant, do_pop;
        logic [AW-1:0] gaddr;
        bus.mem_gnt        = gnt;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rpc;
        @(negedge clk);
        exp_req = (q.size() + int'(m_infl) < DEPTH) && !rdr;
        exp_vld = (q.size() != 0) && !rdr;
        chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
        if (exp_req) chk("mem_raddr", 64'(bus.mem_raddr), 64'(m_fetch));
        chk("instr_valid", 64'(bus.instr_valid), 64'(exp_vld));
        if (exp_vld) begin
            chk("instr_pc", 64'(bus.instr_pc), 64'(q[0].pc));
            chk("instr_data", 64'(bus.instr_data), 64'(q[0].data));
        end
        chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
        do_pop   = exp_vld && rdy;
        do_grant = exp_req && gnt;
        gaddr    = m_fetch;
        @(posedge clk);
        if (rdr) begin
            q.delete();
            m_kill  = m_infl;
            m_infl  = 0;
            m_fetch = rpc;
        end else begin
            if (do_pop) begin
                popped.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (m_infl && !m_kill) q.push_back('{pc: m_rsp_pc, data: mem_word(m_rsp_pc)});
            m_kill = 0;
            if (do_grant) begin
                grants.push_back(gaddr);
                m_rsp_pc = gaddr;
                m_fetch  = gaddr + AW'(1);
                m_infl   = 1;
            end else begin
                m_infl = 0;
            end
        end
        #1;
        bus.mem_rdata = do_grant ? mem_word(gaddr) : DW'($urandom);
    endtask

    task automatic set_in(input bit g, input bit r, input bit d, input logic [AW-1:0] p);
        gnt = g; rdy = r; rdr = d; rpc = p;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"},     64'(bus.mem_req), 64'(0));
        chk({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'(0));
        chk({tag, "_instr_data"},  64'(bus.instr_data), 64'(0));
        chk({tag, "_instr_pc"},    64'(bus.instr_pc), 64'(0));
        chk({tag, "_occupancy"},   64'(bus.occupancy), 64'(0));
    endtask

    initial begin
        int guard;
        bus.mem_gnt = 0; bus.instr_ready = 0; bus.redirect_valid = 0;
        bus.redirect_pc = '0; bus.mem_rdata = '0;
        set_in(0, 0, 0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk) rst = 1;
        @(posedge clk); #1;

        // Fill
        grants.delete();
        set_in(1, 0, 0, '0);
        repeat (8) step();
        chk("fill_grants", 64'(grants.size()), 64'(4));
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("fill_addr", 64'(grants[i]), 64'(i));
        chk("fill_occ", 64'(bus.occupancy), 64'(4));
        chk("fill_req_low", 64'(bus.mem_req), 64'(0));
        chk("fill_head_pc", 64'(bus.instr_pc), 64'(0));
        chk("fill_head_data", 64'(bus.instr_data), 64'(32'h1000));

        // Stream
        popped.delete();
        set_in(1, 1, 0, '0);
        repeat (12) step();
        chk("stream_count", 64'(popped.size()), 64'(12));
        for (int i = 0; i < popped.size(); i++) chk("stream_pc", 64'(popped[i]), 64'(i));

        // Grant stall at fetch_pc = 2
        set_in(0, 1, 1, 32'd2);
        step();
        grants.delete();
        set_in(0, 1, 0, '0);
        repeat (5) begin
            step();
            chk("stall_raddr", 64'(bus.mem_raddr), 64'(2));
            chk("stall_req", 64'(bus.mem_req), 64'(1));
        end
        chk("stall_occ", 64'(bus.occupancy), 64'(0));
        chk("stall_nogrant", 64'(grants.size()), 64'(0));
        popped.delete();
        set_in(1, 1, 0, '0);
        repeat (6) step();
        chk("stall_resume", 64'(grants[0]), 64'(2));
        chk("stall_pop0", 64'(popped[0]), 64'(2));
        chk("stall_pop1", 64'(popped[1]), 64'(3));

        // Redirect with a request in flight
        set_in(0, 0, 1, 32'd5);
        step();
        grants.delete();
        set_in(1, 0, 0, '0);
        step();
        chk("rdr_grant5", 64'(grants[0]), 64'(5));
        set_in(1, 1, 1, 32'h40);
        step();
        chk("rdr_empty", 64'(bus.occupancy), 64'(0));
        grants.delete();
        popped.delete();
        set_in(1, 1, 0, '0);
        repeat (6) step();
        chk("rdr_next_req", 64'(grants[0]), 64'(32'h40));
        chk("rdr_next_pop", 64'(popped[0]), 64'(32'h40));

        // Redirect while popping with occupancy 3
        set_in(0, 0, 1, 32'h100);
        step();
        guard = 0;
        while (q.size() != 3 && guard < 20) begin
            set_in((q.size() + int'(m_infl)) < 3, 0, 0, '0);
            step();
            guard++;
        end
        chk("pop_rdr_setup", 64'(bus.occupancy), 64'(3));
        popped.delete();
        set_in(1, 1, 1, 32'h200);
        step();
        chk("pop_rdr_nopop", 64'(popped.size()), 64'(0));
        chk("pop_rdr_occ", 64'(bus.occupancy), 64'(0));

        // Address wrap
        set_in(0, 0, 1, 32'hFFFF_FFFE);
        step();
        grants.delete();
        popped.delete();
        set_in(1, 1, 0, '0);
        repeat (8) step();
        chk("wrap_a0", 64'(grants[0]), 64'(32'hFFFF_FFFE));
        chk("wrap_a1", 64'(grants[1]), 64'(32'hFFFF_FFFF));
        chk("wrap_a2", 64'(grants[2]), 64'(0));
        chk("wrap_a3", 64'(grants[3]), 64'(1));
        chk("wrap_p0", 64'(popped[0]), 64'(32'hFFFF_FFFE));
        chk("wrap_p1", 64'(popped[1]), 64'(32'hFFFF_FFFF));
        chk("wrap_p2", 64'(popped[2]), 64'(0));
        chk("wrap_p3", 64'(popped[3]), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] p;
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + AW'($urandom_range(0, 3))) : AW'($urandom);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 11) == 0, p);
            step();
        end

        // Async reset in the middle of a stream
        set_in(0, 0, 1, 32'h80);
        step();
        set_in(1, 1, 0, '0);
        repeat (5) step();
        #3 rst = 0;
        #1;
        chk_reset_outputs("arst");
        model_reset();
        set_in(0, 0, 0, '0);
        bus.mem_gnt = 0;
        bus.instr_ready = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        grants.delete();
        popped.delete();
        set_in(1, 1, 0, '0);
        repeat (6) step();
        chk("arst_restart", 64'(grants[0]), 64'(0));
        chk("arst_pop0", 64'(popped[0]), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
